// File: rtl/spy_delay_pkg.sv
// spy_delay_pkg: shared FSM states and parameter defaults for the spy delay-path prober and path wrapper
package spy_delay_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int DLY_W_DEF = 4;
  localparam bit PATH_INVERTS_DEF = 1'b0;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_SETTLE, S_DONE} state_t;
endpackage

// File: rtl/path_capture_ff.sv
// path_capture_ff: raw capture flop for the delay-path output, kept apart so it can be placed and constrained alone
module path_capture_ff (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);
  (* keep = 1 *) logic r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= 1'b0;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/delay_path_prober.sv
// delay_path_prober: launches transitions into a delay path, captures its output a set number of edges later
// and counts trials whose captured value differs from the settled expectation.
module delay_path_prober
  import spy_delay_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int DLY_W         = DLY_W_DEF,
  parameter int SETTLE_CYCLES = 8,
  parameter bit PATH_INVERTS  = PATH_INVERTS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] trialCount,
  input  logic [DLY_W-1:0] captureDelay,
  output logic             pathInput,
  input  logic             pathResult,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] errorCount,
  output logic             lastSample
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_t           r_state;
  logic [CNT_W-1:0] r_trials;
  logic [DLY_W-1:0] r_cap_dly;
  logic [DLY_W-1:0] r_dly;
  logic [SW-1:0]    r_set;
  logic             r_chk;
  logic             w_cap_en;
  assign w_cap_en = r_state == S_CAPTURE;
  path_capture_ff u_cap (
    .clk (clk),
    .rst (rst),
    .i_en(w_cap_en),
    .i_d (pathResult),
    .o_q (lastSample)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      r_trials   <= '0;
      r_cap_dly  <= '0;
      r_dly      <= '0;
      r_set      <= '0;
      r_chk      <= 1'b0;
      pathInput  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      errorCount <= '0;
    end else begin
      done  <= 1'b0;
      r_chk <= 1'b0;
      // compare the edge after capture, against the value launched this trial
      if (r_chk && lastSample != (pathInput ^ PATH_INVERTS) && errorCount != '1)
        errorCount <= errorCount + 1'b1;
      case (r_state)
        S_IDLE:
          if (start) begin
            r_trials   <= trialCount;
            r_cap_dly  <= captureDelay;
            errorCount <= '0;
            busy       <= 1'b1;
            r_state    <= trialCount == '0 ? S_DONE : S_LAUNCH;
          end
        S_LAUNCH: begin
          pathInput <= ~pathInput;
          r_dly     <= r_cap_dly == '0 ? '0 : r_cap_dly - 1'b1;
          r_state   <= S_WAIT;
        end
        S_WAIT:
          if (r_dly == '0) r_state <= S_CAPTURE;
          else r_dly <= r_dly - 1'b1;
        S_CAPTURE: begin
          r_chk    <= 1'b1;
          r_trials <= r_trials - 1'b1;
          r_set    <= SW'(SETTLE_CYCLES - 1);
          r_state  <= S_SETTLE;
        end
        S_SETTLE:
          if (r_set == '0) r_state <= r_trials != '0 ? S_LAUNCH : S_DONE;
          else r_set <= r_set - 1'b1;
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_delay_path_prober.sv
// tb_delay_path_prober: drives two probers through behavioural delay paths and checks counts, timing and reset
module tb_delay_path_prober;
  logic clk = 0, rst = 0, start = 0, sel = 0;
  logic [15:0] trial_count = 0;
  logic [3:0] capture_delay = 0;
  logic pi1, pi2, busy1, busy2, done1, done2, last1, last2;
  logic [15:0] err1;
  logic [3:0] err2;
  logic pr1 = 0, pr2 = 0;
  int pd = 3;
  logic path_inv = 0;
  int n_chk = 0, n_fail = 0, tog = 0;
  logic mpi [2];
  logic mlast [2];
  always #5 clk = ~clk;
  delay_path_prober u_dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .trialCount(trial_count), .captureDelay(capture_delay),
    .pathInput(pi1), .pathResult(pr1), .busy(busy1), .done(done1), .errorCount(err1), .lastSample(last1)
  );
  delay_path_prober #(.CNT_W(4), .SETTLE_CYCLES(2), .PATH_INVERTS(1)) u_sat (
    .clk(clk), .rst(rst), .start(start & sel), .trialCount(trial_count[3:0]), .captureDelay(capture_delay),
    .pathInput(pi2), .pathResult(pr2), .busy(busy2), .done(done2), .errorCount(err2), .lastSample(last2)
  );
  // behavioural paths: output follows input (optionally inverted) pd time units later
  always @(pi1 or path_inv) begin #(pd); pr1 = pi1 ^ path_inv; end
  always @(pi2 or path_inv) begin #(pd); pr2 = pi2 ^ path_inv; end
  wire d_pi = sel ? pi2 : pi1;
  wire d_busy = sel ? busy2 : busy1;
  wire d_done = sel ? done2 : done1;
  wire d_last = sel ? last2 : last1;
  wire [15:0] d_err = sel ? {12'd0, err2} : err1;
  always @(d_pi) tog++;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  function automatic int exp_err(bit s, int n, int cd, int p, bit pinv);
    int d = cd == 0 ? 1 : cd;
    int cap = s ? 15 : 65535;
    bit bad = pinv ^ s ^ (p > (d + 1) * 10);
    return bad ? (n > cap ? cap : n) : 0;
  endfunction
  function automatic int exp_cyc(bit s, int n, int cd);
    return 2 + n * (2 + (cd == 0 ? 1 : cd) + (s ? 2 : 8));
  endfunction
  task automatic run(input bit s, input int n, input int cd, input int p, input bit pinv, input int mid,
                     input int err_want, input int cyc_want, input string tag);
    int d, cyc, t0;
    logic pi_f, cap;
    @(negedge clk);
    sel = s; pd = p; path_inv = pinv;
    repeat (12) @(negedge clk);
    d = cd == 0 ? 1 : cd;
    pi_f = mpi[s] ^ n[0];
    cap = pi_f ^ pinv ^ (p > (d + 1) * 10);
    if (n > 0) mlast[s] = cap;
    mpi[s] = pi_f;
    t0 = tog;
    trial_count = 16'(n); capture_delay = 4'(cd); start = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, " busy"}, 32'(d_busy), 1);
      start = cyc == mid;
      if (start) trial_count = 16'd9;
    end while (!d_done && cyc < 2000);
    start = 0;
    check({tag, " cycles"}, cyc, cyc_want);
    check({tag, " errorCount"}, d_err, err_want);
    check({tag, " pathInput"}, 32'(d_pi), 32'(mpi[s]));
    check({tag, " lastSample"}, 32'(d_last), 32'(mlast[s]));
    check({tag, " toggles"}, tog - t0, n);
    check({tag, " busy at done"}, 32'(d_busy), 0);
    @(negedge clk);
    check({tag, " done width"}, 32'(d_done), 0);
  endtask
  typedef struct {bit s; int n; int cd; int pd; bit pinv; int mid; int err; int cyc;} vec_t;
  vec_t vecs[14];
  initial begin
    vecs = '{
      '{0, 10, 1, 3, 0, 0, 0, 112},   '{0, 10, 1, 25, 0, 0, 10, 112}, '{0, 10, 3, 25, 0, 0, 0, 132},
      '{0, 0, 5, 3, 0, 0, 0, 2},      '{0, 4, 0, 3, 0, 0, 0, 46},     '{0, 4, 1, 15, 0, 0, 0, 46},
      '{0, 6, 2, 3, 1, 0, 6, 74},     '{0, 5, 1, 3, 0, 20, 0, 57},    '{0, 3, 15, 100, 0, 0, 0, 77},
      '{0, 2, 7, 85, 0, 0, 2, 36},    '{1, 7, 1, 3, 1, 0, 0, 37},     '{1, 15, 1, 3, 0, 0, 15, 77},
      '{1, 4, 2, 25, 1, 0, 0, 26},    '{1, 3, 1, 25, 1, 0, 3, 17}
    };
    mpi = '{0, 0};
    mlast = '{0, 0};
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check("reset pathInput", 32'(pi1), 0);
    check("reset busy", 32'(busy1), 0);
    check("reset done", 32'(done1), 0);
    check("reset errorCount", err1, 0);
    check("reset lastSample", 32'(last1), 0);
    rst = 0;
    foreach (vecs[i])
      run(vecs[i].s, vecs[i].n, vecs[i].cd, vecs[i].pd, vecs[i].pinv, vecs[i].mid, vecs[i].err, vecs[i].cyc,
          $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) begin
      automatic int n = $urandom_range(0, 6);
      automatic int cd = $urandom_range(0, 4);
      automatic int p = 10 * $urandom_range(0, 5) + 5;
      automatic bit pv = 1'($urandom_range(0, 1));
      run(0, n, cd, p, pv, 0, exp_err(0, n, cd, p, pv), exp_cyc(0, n, cd), $sformatf("rand%0d", i));
    end
    // reset in the WAIT state of trial 3 of a failing run
    @(negedge clk);
    sel = 0; pd = 35; path_inv = 0;
    repeat (12) @(negedge clk);
    trial_count = 16'd5; capture_delay = 4'd2; start = 1;
    @(negedge clk);
    start = 0;
    repeat (25) @(negedge clk);
    check("mid-run errorCount", err1, 2);
    check("mid-run busy", 32'(busy1), 1);
    #2 rst = 1;
    #1;
    check("async rst pathInput", 32'(pi1), 0);
    check("async rst busy", 32'(busy1), 0);
    check("async rst errorCount", err1, 0);
    check("async rst lastSample", 32'(last1), 0);
    repeat (3) @(negedge clk);
    check("rst no done", 32'(done1), 0);
    rst = 0;
    mpi = '{0, 0};
    mlast = '{0, 0};
    repeat (3) @(negedge clk);
    check("after rst no done", 32'(done1), 0);
    run(0, 3, 1, 3, 0, 0, 0, 35, "post-reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
